// File: rtl/riscv_ifetch_unit.sv
// Instruction-fetch front end: issues word reads to the instruction ROM under a
// credit limit, buffers returned words with their PCs, and hands them to decode.
module riscv_ifetch_unit #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned INST_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_en,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          rom_en,
    input  logic [INST_W-1:0]             rom_data,
    input  logic                          redirect_valid,
    input  logic [ADDR_W+1:0]             redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [INST_W-1:0]             inst_data,
    output logic [ADDR_W+1:0]             inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PC_W  = ADDR_W + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [PC_W-1:0]   RESET_PC_B = PC_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] RESET_WORD = RESET_PC_B[PC_W-1:2];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
    logic                inflight_q, inflight_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [INST_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic [INST_W-1:0]   mem_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_d [FIFO_DEPTH];

    logic issue_c;
    logic push_c;
    logic pop_c;
    logic credit_next_c;
    logic unused_pc_lsb_c;

    assign unused_pc_lsb_c = ^redirect_pc[1:0];

    // Outstanding work (buffered + in flight) never exceeds the buffer depth.
    always_comb begin
        issue_c = (state_q == FETCH) && fetch_en && !redirect_valid &&
                  ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH));
        push_c  = inflight_q && !redirect_valid;
        pop_c   = (count_q != '0) && inst_ready && !redirect_valid;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_addr_d   = resp_addr_q;
        inflight_d    = issue_c;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mem_data_d    = mem_data_q;
        mem_addr_d    = mem_addr_q;
        credit_next_c = 1'b0;

        if (issue_c) begin
            fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
            resp_addr_d = fetch_pc_q;
        end

        // A redirect flushes the buffer and drops the response arriving now.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc[PC_W-1:2];
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push_c) begin
                mem_data_d[wr_ptr_q] = rom_data;
                mem_addr_d[wr_ptr_q] = resp_addr_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        // Stall decision looks at next-cycle credit so no cycle is lost on resume.
        credit_next_c = (SUM_W'(count_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH);
        if (!fetch_en) begin
            state_d = IDLE;
        end else if ((state_q == IDLE) || credit_next_c) begin
            state_d = FETCH;
        end else begin
            state_d = STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_WORD;
            resp_addr_q <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_data_q  <= '{default: '0};
            mem_addr_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_addr_q <= resp_addr_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_data_q  <= mem_data_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            assert (count_q < CNT_W'(FIFO_DEPTH))
                else $error("riscv_ifetch_unit: push into a full instruction buffer");
        end
    end

    assign rom_en     = issue_c;
    assign rom_addr   = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? mem_data_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? {mem_addr_q[rd_ptr_q], 2'b00} : '0;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_riscv_ifetch_unit.sv
// Bench for riscv_ifetch_unit: directed scenarios plus random traffic checked
// against a stream-level model of issued addresses and delivered PCs.
module tb_riscv_ifetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        inst_ready = 1'b0;

    logic [7:0]  rom_addr, rom_addr2;
    logic        rom_en, rom_en2;
    logic [31:0] rom_data = '0;
    logic [31:0] rom_data2 = '0;
    logic        inst_valid, inst_valid2;
    logic [31:0] inst_data, inst_data2;
    logic [9:0]  inst_pc, inst_pc2;
    logic [2:0]  fifo_count, fifo_count2;

    int n_assert = 0;
    int n_fail   = 0;

    // Stream model: next PC decode must see, next address the ROM must see,
    // and work outstanding since the last flush.
    logic [9:0]  exp_pc;
    logic [7:0]  exp_issue;
    int          occ;
    bit          fe_prev;
    bit          prev_issue;
    bit          exp_en;
    bit          exp_valid;

    riscv_ifetch_unit #(.ADDR_W(8), .INST_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(0)) u_dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .fifo_count(fifo_count)
    );

    riscv_ifetch_unit #(.ADDR_W(8), .INST_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h3F8)) u_wrap (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
        .redirect_valid(1'b0), .redirect_pc(10'h000),
        .inst_valid(inst_valid2), .inst_ready(inst_ready),
        .inst_data(inst_data2), .inst_pc(inst_pc2), .fifo_count(fifo_count2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return 32'h1000_0000 + {24'h0, a};
    endfunction

    always @(posedge clk) begin
        if (rom_en)  rom_data  <= rom_word(rom_addr);
        if (rom_en2) rom_data2 <= rom_word(rom_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
            end
    endtask

    task automatic reset_model();
        exp_pc     = 10'h000;
        exp_issue  = 8'h00;
        occ        = 0;
        fe_prev    = 1'b0;
        prev_issue = 1'b0;
    endtask

    // Apply inputs for one cycle and check outputs mid-cycle against the model.
    task automatic drive(input bit fe, input bit rv, input logic [9:0] rpc, input bit rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        @(negedge clk);
        exp_en    = fe && fe_prev && !rv && (occ < int'(DEPTH));
        exp_valid = (occ - int'(prev_issue)) != 0;
        chk("rom_en", 32'(rom_en), 32'(exp_en));
        chk("rom_addr", 32'(rom_addr), 32'(exp_issue));
        chk("fifo_count", 32'(fifo_count), 32'(occ - int'(prev_issue)));
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_pc", 32'(inst_pc), 32'(exp_pc));
            chk("inst_data", inst_data, rom_word(exp_pc[9:2]));
        end
    endtask

    // Update the model with this cycle's events, then move to the next cycle.
    task automatic advance();
        if (redirect_valid) begin
            exp_pc    = {redirect_pc[9:2], 2'b00};
            exp_issue = redirect_pc[9:2];
            occ       = 0;
        end else begin
            if (exp_valid && inst_ready) begin
                exp_pc = exp_pc + 10'd4;
                occ--;
            end
            if (exp_en) begin
                exp_issue = exp_issue + 8'd1;
                occ++;
            end
        end
        fe_prev    = fetch_en;
        prev_issue = exp_en;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit fe, input bit rv, input logic [9:0] rpc, input bit rdy);
        drive(fe, rv, rpc, rdy);
        advance();
    endtask

    initial begin
        logic [7:0] a2;
        logic [9:0] p2;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h00);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", 32'(inst_pc), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_wrap_rom_addr", 32'(rom_addr2), 32'hFE);
        rst = 1'b0;
        reset_model();

        // Streaming from reset; the second instance exercises the address wrap
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, 10'h000, 1'b1);
            if (k >= 1 && k <= 3) begin
                a2 = 8'hFD;
                a2 = a2 + 8'(k);
                chk("wrap_rom_en", 32'(rom_en2), 32'h1);
                chk("wrap_rom_addr", 32'(rom_addr2), 32'(a2));
            end
            if (k >= 3 && k <= 5) begin
                p2 = 10'h3F8;
                p2 = p2 + 10'(4 * (k - 3));
                chk("wrap_inst_valid", 32'(inst_valid2), 32'h1);
                chk("wrap_inst_pc", 32'(inst_pc2), 32'(p2));
                chk("wrap_inst_data", inst_data2, rom_word(p2[9:2]));
            end
            if (k >= 3) chk("throughput_valid", 32'(inst_valid), 32'h1);
            advance();
        end

        // Backpressure saturates the buffer
        repeat (10) tick(1'b1, 1'b0, 10'h000, 1'b0);
        drive(1'b1, 1'b0, 10'h000, 1'b0);
        chk("sat_count", 32'(fifo_count), 32'(DEPTH));
        chk("sat_rom_en", 32'(rom_en), 32'h0);
        advance();
        repeat (8) tick(1'b1, 1'b0, 10'h000, 1'b1);

        // Redirect with three buffered entries and one request in flight
        for (int i = 0; i < 20 && !(occ == int'(DEPTH) && prev_issue); i++)
            tick(1'b1, 1'b0, 10'h000, 1'b0);
        drive(1'b1, 1'b1, 10'h040, 1'b0);
        chk("redir_pre_count", 32'(fifo_count), 32'h3);
        advance();
        drive(1'b1, 1'b0, 10'h000, 1'b1);
        chk("redir_inst_valid", 32'(inst_valid), 32'h0);
        chk("redir_rom_addr", 32'(rom_addr), 32'h10);
        chk("redir_rom_en", 32'(rom_en), 32'h1);
        advance();
        repeat (6) tick(1'b1, 1'b0, 10'h000, 1'b1);

        // Redirect near the top of the address space
        tick(1'b1, 1'b1, 10'h3F8, 1'b1);
        repeat (8) tick(1'b1, 1'b0, 10'h000, 1'b1);

        // fetch_en dropped mid-stream, then re-enabled
        drive(1'b0, 1'b0, 10'h000, 1'b1);
        chk("fe_drop_rom_en", 32'(rom_en), 32'h0);
        advance();
        repeat (6) tick(1'b0, 1'b0, 10'h000, 1'b1);
        repeat (6) tick(1'b1, 1'b0, 10'h000, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 10'($urandom), $urandom_range(0, 9) < 7);
        end

        // Asynchronous reset while an entry is held
        repeat (4) tick(1'b1, 1'b0, 10'h000, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(inst_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rom_en", 32'(rom_en), 32'h0);
        chk("arst_inst_valid", 32'(inst_valid), 32'h0);
        chk("arst_inst_data", inst_data, 32'h0);
        chk("arst_inst_pc", 32'(inst_pc), 32'h0);
        chk("arst_fifo_count", 32'(fifo_count), 32'h0);
        chk("arst_rom_addr", 32'(rom_addr), 32'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        repeat (8) tick(1'b1, 1'b0, 10'h000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_ifetch_unit.md
Name: riscv_ifetch_unit

Overview:
- Instruction-fetch front end of the RISC-V core. Drives the word-addressed instruction ROM (rom_addr/rom_en, 1-cycle read latency), buffers returned words with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake.
- Handles sequential PC increment, branch/jump redirect with flush, and backpressure from decode.

Parameters:
- ADDR_W, 8, ROM word-address width; byte PC width is ADDR_W+2.
- INST_W, 32, instruction width.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2.
- RESET_PC, 0, byte PC fetched first after reset; bits [1:0] ignored.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- fetch_en, in, 1, enables issuing new ROM requests.
- rom_addr, out, ADDR_W, ROM word address.
- rom_en, out, 1, ROM read strobe; data returns on rom_data in the next cycle.
- rom_data, in, INST_W, ROM read data.
- redirect_valid, in, 1, branch/jump taken this cycle.
- redirect_pc, in, ADDR_W+2, byte target PC; bits [1:0] ignored.
- inst_valid, out, 1, inst_data/inst_pc hold a valid entry.
- inst_ready, in, 1, decode accepts the entry this cycle.
- inst_data, out, INST_W, instruction word.
- inst_pc, out, ADDR_W+2, byte PC of inst_data; bits [1:0] always 0.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, current buffer occupancy (debug/verification).

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, fetch_pc=RESET_PC[ADDR_W+1:2], inflight=0, FIFO empty.
  - rom_en=0, rom_addr=fetch_pc, inst_valid=0, inst_data=0, inst_pc=0, fifo_count=0.
- FSM states: IDLE, FETCH, STALL.
  - IDLE -> FETCH on the first clock edge after reset release with fetch_en=1.
  - FETCH -> STALL when fetch_en=1 and credits are exhausted.
  - STALL -> FETCH when credits free up.
  - FETCH/STALL -> IDLE when fetch_en=0.
  - IDLE/STALL -> FETCH on redirect, provided fetch_en=1.
- Credit rule:
  - issue = (state==FETCH) & fetch_en & ~redirect_valid & (fifo_count + inflight < FIFO_DEPTH).
  - A pop in the same cycle is not credited.
  - rom_en = issue (combinational); rom_addr = fetch_pc at all times.
- On issue:
  - fetch_pc <= fetch_pc+1, mod 2^ADDR_W (0xFF wraps to 0x00).
  - inflight <= 1, and the issued address is latched as resp_addr.
  - Without issue, inflight <= 0.
- Response capture:
  - In the cycle after an issue, rom_data is pushed with pc {resp_addr,2'b00}, unless redirect_valid=1 in that cycle, in which case it is discarded.
  - A push is visible on the outputs the following cycle. Minimum latency is rom_en at cycle N to inst_valid at cycle N+2.
- Output:
  - inst_valid = FIFO non-empty.
  - inst_data and inst_pc come from the FIFO head.
  - The head and inst_valid stay stable until inst_valid & inst_ready.
  - Pop and push in the same cycle are both honoured; count is unchanged.
- Redirect (redirect_valid=1 in cycle t):
  - FIFO cleared at the edge ending cycle t, so inst_valid=0 in cycle t+1.
  - The response arriving in cycle t is dropped; no issue occurs in cycle t.
  - fetch_pc <= redirect_pc[ADDR_W+1:2], and the first target request is issued in cycle t+1.
  - Redirect has priority over push, pop and fetch_en.
  - A handshake completing in cycle t counts as consumed.
- Overflow is impossible by the credit rule; a push into a full FIFO is a design error and must be asserted against in simulation.
- Throughput: with inst_ready=1 held, one instruction per cycle in steady state.
- Reset asserted mid-operation returns every register to its reset value immediately. An in-flight ROM response is ignored.

Test Plan:
- Reset release, fetch_en=1, inst_ready=1, ROM[i]=0x1000_0000+i -> rom_en at cycle 1 with addr 0x00; inst_valid at cycle 3 with pc 0x000 and data 0x1000_0000; then consecutive pcs 0x004, 0x008, … one per cycle.
- inst_ready=0 for 10 cycles -> fifo_count reaches 4 and stays there, rom_en=0 while saturated, head pc unchanged; on inst_ready=1, fetching resumes with no lost or duplicated pc.
- redirect_valid with redirect_pc=0x040 while the FIFO holds 3 entries and one request is in flight -> next cycle inst_valid=0 and rom_addr=0x10 with rom_en=1; first delivered pc=0x040; no stale pcs appear.
- Start at RESET_PC=0x3F8 -> pcs 0x3F8, 0x3FC, 0x000; rom_addr wraps 0xFF to 0x00.
- fetch_en dropped mid-stream -> rom_en=0 the same cycle; already-fetched entries drain; re-enable resumes at the next sequential pc.
- rst pulsed while inst_valid=1 -> all outputs return to 0 asynchronously; after release, fetch restarts at RESET_PC.
